usiq_sched: RTL
===============

# usiq_sched

Round-robin scheduler that drains up to NRX upstream receiver IQ FIFOs into one shared AXI-stream-style sample stream feeding the upstream packet builder. It grants one FIFO at a time for exactly one packet, which ends at a `tlast` beat. A FIFO is only granted once it holds at least THRESH entries. An optional watchdog terminates packets whose source stalls mid-packet, so the shared stream cannot be held indefinitely.

## Interface
Parameters:
- NRX, 4: number of requesting FIFOs, 1..8.
- THRESH, 11'd64: minimum `s_tlength` for eligibility.
- TIMEOUT, 1024: watchdog stall limit in clocks; only used with the watchdog macro.

Ports:
- clk  in  1  single clock; all FIFO read ports run on it.
- rstn  in  1  reset; synchronous, active-low.
- rx_en  in  NRX  per-source enable mask.
- s_tdata  in  24*NRX  packed sample data; source i is at [24i+23:24i].
- s_tvalid  in  NRX  per-source valid.
- s_tready  out  NRX  per-source pop strobe.
- s_tlast  in  NRX  per-source end of packet.
- s_tuser  in  2*NRX  per-source sideband.
- s_tlength  in  11*NRX  per-source FIFO fill level.
- m_tdata  out  24  merged data.
- m_tvalid  out  1  merged valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  merged end of packet.
- m_tuser  out  2  merged sideband.
- m_tid  out  3  index of the granted source.
- busy  out  1  high in XFER or ABORT.
- pkt_count  out  16  completed packets; wraps.
- abort_count  out  8  watchdog aborts; saturates at 255.

## Operation
- State machine: IDLE, XFER, ABORT.
- Eligible(i) = rx_en[i] & s_tvalid[i] & (s_tlength[i] >= THRESH). The compare is 11-bit unsigned.
- IDLE: search sources starting at ptr, ascending and wrapping mod NRX. On the first eligible source i, register grant=i and move to XFER. If none is eligible, stay in IDLE.
- XFER:
  - m_tdata, m_tuser and m_tlast are the granted source's signals, muxed combinationally.
  - m_tvalid = s_tvalid[grant].
  - s_tready[grant] = m_tready. All other s_tready bits are 0.
  - A handshake is m_tvalid & m_tready.
  - A handshake with s_tlast[grant] ends the packet: pkt_count+1, ptr=(grant+1) mod NRX, next state IDLE.
- Deasserting rx_en[grant] mid-packet has no effect. The packet completes, and the source is excluded from later searches.
- ABORT (watchdog only):
  - Drive m_tvalid=1, m_tdata=0, m_tlast=1, m_tuser=2'b11.
  - s_tready is all 0; the stalled source is not popped.
  - On m_tready: abort_count+1 (saturating), ptr=(grant+1) mod NRX, next state IDLE.
- m_tid = grant in XFER and ABORT, otherwise 0.
- Outside XFER and ABORT: m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0, and s_tready is all 0.

## Timing
- Reset (rstn=0 at a clk edge):
  - State IDLE, ptr=0, grant=0, pkt_count=0, abort_count=0, watchdog counter=0.
  - All outputs are 0 from the following cycle.
  - A reset mid-packet abandons the packet with no terminating beat.
- Arbitration latency is 1 clk: eligibility seen in cycle N gives XFER and m_tvalid in cycle N+1.
- There is 1 idle clk between back-to-back packets: the last beat in cycle N, IDLE in N+1, the next grant visible in N+2.
- The data path is combinational from s_* to m_* in XFER, with no added latency. m_tready to s_tready is combinational.
- m_* is held stable while m_tvalid=1 and m_tready=0, provided the source obeys the same rule.
- s_tlength is sampled only in IDLE. Changes during XFER are ignored.
- With NRX=1 the pointer is always 0.

## Configuration
- USIQ_SCHED_WATCHDOG_EN defined:
  - In XFER, a counter increments each clk that s_tvalid[grant]=0 and clears on each handshake.
  - When the count reaches TIMEOUT, the block enters ABORT on the next clk.
  - The counter clears on entry to IDLE.
- Not defined:
  - No counter and no ABORT state; XFER waits indefinitely.
  - abort_count is tied to 0.

## Test plan
- NRX=4, THRESH=64; sources 0 and 2 at length 100 with 4-beat packets, m_tready=1 → packets come from 0 then 2 then 0. m_tid matches. One idle clk separates packets. pkt_count=3.
- Source 1 at length 63, source 3 at length 64 → only source 3 is granted. Raising source 1 to 64 → source 1 is granted after the next packet boundary.
- m_tready toggles 1,0,1,0 during a packet → every beat appears exactly once and s_tready[grant] mirrors m_tready. The data sequence out equals the data sequence in.
- rx_en[0] cleared on beat 2 of a 4-beat packet from source 0 → all 4 beats complete. Source 0 is then never regranted while it stays disabled.
- Watchdog on, TIMEOUT=16; source 2 drops s_tvalid after beat 1 → after 16 stalled clks a single beat appears with tlast=1, tuser=2'b11, tdata=0. abort_count=1 and the next search starts at source 3.
- rstn=0 for 1 clk during XFER → next cycle all outputs are 0 and the counters are 0. The first grant after reset is the lowest eligible index.

Source files
------------

// File: rtl/usiq_sched.sv
// Round-robin scheduler that drains up to NRX receiver IQ FIFOs into one shared sample stream.
// Optional stall watchdog enabled by defining USIQ_SCHED_WATCHDOG_EN.
`timescale 1ns/1ps

module usiq_sched #(
    parameter int          NRX     = 4,
    parameter logic [10:0] THRESH  = 11'd64,
    parameter int          TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NRX-1:0]    rx_en,
    input  logic [24*NRX-1:0] s_tdata,
    input  logic [NRX-1:0]    s_tvalid,
    output logic [NRX-1:0]    s_tready,
    input  logic [NRX-1:0]    s_tlast,
    input  logic [2*NRX-1:0]  s_tuser,
    input  logic [11*NRX-1:0] s_tlength,
    output logic [23:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [1:0]        m_tuser,
    output logic [2:0]        m_tid,
    output logic              busy,
    output logic [15:0]       pkt_count,
    output logic [7:0]        abort_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_ptr;
    logic [2:0]     r_grant;
    logic [2:0]     w_pick;
    logic [2:0]     w_ptr_nxt;
    logic [15:0]    r_pkt_count;
    logic [NRX-1:0] w_elig;
    logic           w_found;
    logic           w_g_valid;
    logic           w_g_last;
    logic [23:0]    w_g_data;
    logic [1:0]     w_g_user;
    logic           w_hs;
    logic           w_pkt_done;
    logic           w_abort_done;

    always_comb begin
        for (int i = 0; i < NRX; i++) begin
            w_elig[i] = rx_en[i] & s_tvalid[i] & (s_tlength[11*i +: 11] >= THRESH);
        end
    end

    // First eligible source at or after r_ptr, wrapping modulo NRX.
    always_comb begin : search
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NRX; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NRX) idx = idx - NRX;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_pick  = 3'(idx);
            end
        end
    end

    // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        w_g_user  = '0;
        for (int i = 0; i < NRX; i++) begin
            if (r_grant == 3'(i)) begin
                w_g_valid = s_tvalid[i];
                w_g_last  = s_tlast[i];
                w_g_data  = s_tdata[24*i +: 24];
                w_g_user  = s_tuser[2*i +: 2];
            end
        end
    end

    assign w_ptr_nxt  = (r_grant >= 3'(NRX - 1)) ? 3'd0 : r_grant + 3'd1;
    assign w_hs       = (r_state == ST_XFER) & w_g_valid & m_tready;
    assign w_pkt_done = w_hs & w_g_last;

`ifdef USIQ_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] r_wd;
    logic [7:0]     r_abort_count;
    logic           w_wd_fire;

    // Fires on the stalled clock that brings the count up to TIMEOUT.
    assign w_wd_fire    = (r_state == ST_XFER) & ~w_g_valid & (r_wd == WDW'(TIMEOUT - 1));
    assign w_abort_done = (r_state == ST_ABORT) & m_tready;
    assign abort_count  = r_abort_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wd          <= '0;
            r_abort_count <= '0;
        end else begin
            if (r_state == ST_IDLE || w_hs)
                r_wd <= '0;
            else if (r_state == ST_XFER && !w_g_valid && r_wd != WDW'(TIMEOUT))
                r_wd <= r_wd + 1'b1;
            if (w_abort_done && r_abort_count != 8'hFF)
                r_abort_count <= r_abort_count + 8'd1;
        end
    end
`else
    assign w_abort_done = 1'b0;
    assign abort_count  = 8'd0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tlast     = 1'b0;
        m_tuser     = '0;
        m_tid       = '0;
        s_tready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                m_tvalid = w_g_valid;
                m_tdata  = w_g_data;
                m_tlast  = w_g_last;
                m_tuser  = w_g_user;
                m_tid    = r_grant;
                for (int i = 0; i < NRX; i++) begin
                    if (r_grant == 3'(i)) s_tready[i] = m_tready;
                end
                if (w_pkt_done)
                    w_state_nxt = ST_IDLE;
`ifdef USIQ_SCHED_WATCHDOG_EN
                else if (w_wd_fire)
                    w_state_nxt = ST_ABORT;
`endif
            end
`ifdef USIQ_SCHED_WATCHDOG_EN
            // Terminating beat closes the stalled packet; the source is left unpopped.
            ST_ABORT: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tuser  = 2'b11;
                m_tid    = r_grant;
                if (m_tready) w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_found) r_grant <= w_pick;
            if (w_pkt_done) r_pkt_count <= r_pkt_count + 16'd1;
            if (w_pkt_done || w_abort_done) r_ptr <= w_ptr_nxt;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign pkt_count = r_pkt_count;

endmodule
